// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM.
//   - opcode constants for the supported instructions
//   - alu_op, alu_src_b and pc_source encodings
//   - state enum and the control word emitted by the state decoder
// Optional feature macro: MIPS_CTRL_ADDI_EN adds addi support (S_ADDIEX/S_ADDIWB).
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REG     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MIPS_CTRL_ADDI_EN
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_e;
`else
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_e;
`endif

  // Moore control word. fetch_upd marks the fetch cycle: the top gates it
  // with mem_ready to form ir_write and the PC+4 write.
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       fetch_upd;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    unique case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_LW, OP_SW: ok = 1'b1;
`ifdef MIPS_CTRL_ADDI_EN
      OP_ADDI: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Memory handshake between the control FSM and the unified I/D memory.
//   mem_req   : request valid, held until the cycle mem_ready is seen
//   mem_read  : read access
//   mem_write : write access
//   i_or_d    : address select, 0 = PC, 1 = ALUOut
//   mem_ready : memory completes the current request this cycle
// master = control FSM, slave = memory.
interface mips_multicycle_control_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_read,
    output mem_write,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_read,
    input  mem_write,
    input  i_or_d,
    output mem_ready
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Purely combinational state -> control word decoder for the multicycle MIPS
// control FSM. Unused state encodings decode to an all-zero word.
//   state : current FSM state
//   ctrl  : unqualified Moore control word
// Optional feature macro: MIPS_CTRL_ADDI_EN decodes S_ADDIEX/S_ADDIWB.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.fetch_upd = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        // Branch target into ALUOut ahead of a possible beq.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUSRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Holds the state register,
// next-state logic and the mem_ready/zero qualification of the decoded word.
//   clk, rst_n      : clock, asynchronous active-low reset (state -> S_IDLE)
//   opcode          : instr[31:26] from the IR (sampled in S_DECODE/S_MEMADR)
//   zero            : ALU zero flag
//   mem             : memory handshake (mem_req/read/write/i_or_d, mem_ready)
//   ir_write .. reg_write : datapath enables and mux selects
//   pc_en           : pc_write | (pc_write_cond & zero)
//   illegal_op      : one-cycle pulse in S_DECODE on an unsupported opcode
// Optional feature macro: MIPS_CTRL_ADDI_EN adds addi (S_ADDIEX -> S_ADDIWB).
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  zero,
  mips_multicycle_control_if.master mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  pc_en,
  output logic [1:0]            pc_source,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALUOP_W-1:0]    alu_op,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  illegal_op
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  mips_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem.mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem.mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem.mem_req   = ctrl.mem_req;
    mem.mem_read  = ctrl.mem_read;
    mem.mem_write = ctrl.mem_write;
    mem.i_or_d    = ctrl.i_or_d;

    // IR load and PC+4 commit only once the fetch read actually completes.
    ir_write      = ctrl.fetch_upd & mem.mem_ready;
    pc_write      = ctrl.pc_write | (ctrl.fetch_upd & mem.mem_ready);
    pc_write_cond = ctrl.pc_write_cond;
    pc_en         = pc_write | (ctrl.pc_write_cond & zero);

    pc_source  = ctrl.pc_source;
    alu_src_a  = ctrl.alu_src_a;
    alu_src_b  = ctrl.alu_src_b;
    alu_op     = ctrl.alu_op;
    reg_dst    = ctrl.reg_dst;
    mem_to_reg = ctrl.mem_to_reg;
    reg_write  = ctrl.reg_write;

    illegal_op = (state_q == S_DECODE) && !op_supported(opcode);
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the instruction opcode and sequences the fetch, decode, execute, memory and writeback steps.
- Drives all datapath enables and muxes, plus the 2-bit alu_op consumed by the ALU function decoder (00 = add, 01 = sub, 10 = use funct field).
- Stalls in memory states on a req/ready handshake with the unified instruction/data memory.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, width of alu_op.

Ports:
- clk  in  1  single system clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_read  out  1  read access.
- mem_write  out  1  write access.
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  instruction register load.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- pc_en  out  1  pc_write | (pc_write_cond & zero).
- pc_source  out  2  PC mux: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_op  out  2  to the ALU function decoder.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- State register is updated on posedge clk and cleared asynchronously on negedge rst_n to S_IDLE.
- Outputs are Moore-decoded from state, with exceptions:
  - ir_write, pc_write and the exit from memory states are qualified by mem_ready.
  - illegal_op is qualified by opcode.
- In S_IDLE all outputs are 0; the FSM goes unconditionally to S_FETCH on the next clk.
- S_FETCH:
  - Drives mem_req=1, mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in S_FETCH while mem_ready=0; goes to S_DECODE when mem_ready=1.
- S_DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw): S_MEMADR.
    - 000000 (R-type): S_EXEC.
    - 000100 (beq): S_BRANCH.
    - 000010 (j): S_JUMP.
    - Any other opcode: illegal_op=1 for this cycle, next S_FETCH.
- S_MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD:
  - Drives mem_req=1, mem_read=1, i_or_d=1.
  - Holds while mem_ready=0; goes to S_MEMWB when mem_ready=1.
- S_MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next S_FETCH.
- S_MEMWR:
  - Drives mem_req=1, mem_write=1, i_or_d=1.
  - Holds while mem_ready=0; goes to S_FETCH when mem_ready=1.
- S_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next S_ALUWB.
- S_ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next S_FETCH.
- S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next S_FETCH.
- S_JUMP: pc_write=1, pc_source=10. Next S_FETCH.
- Latencies with mem_ready=1 throughout:
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
  - Each cycle mem_ready is low adds one cycle.
- mem_req stays asserted, with address and read/write selects stable, until the cycle mem_ready=1.
- mem_ready while mem_req=0 is ignored.
- Any unused state encoding recovers to S_FETCH with all outputs 0.
- Reset mid-instruction:
  - All outputs drop to 0 immediately (asynchronous).
  - An in-flight memory request is abandoned.
  - Resumes at S_IDLE, then S_FETCH.
- opcode is sampled only in S_DECODE and S_MEMADR; the IR is stable there.

Optional Feature:
- Macro: MIPS_CTRL_ADDI_EN.
- Defined:
  - Opcode 001000 (addi) in S_DECODE goes to S_ADDIEX, which drives alu_src_a=1, alu_src_b=10, alu_op=00.
  - Then S_ADDIWB, which drives reg_write=1, reg_dst=0, mem_to_reg=0; next S_FETCH.
  - Latency 4 cycles.
- Undefined: 001000 is illegal (illegal_op pulse, back to S_FETCH); states S_ADDIEX and S_ADDIWB do not exist.

Decomposition:
- Package mips_ctrl_pkg holds:
  - Opcode constants.
  - State enum.
  - alu_op encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT).
  - alu_src_b and pc_source encodings.
- One sub-module, mips_ctrl_decode: purely combinational state-to-control-word decoder.
- The top level keeps the state register, next-state logic and the mem_ready/zero qualification.

Test Plan:
- rst_n low mid-S_MEMRD with mem_req=1 -> all outputs 0 at once; after release, S_IDLE then S_FETCH with mem_req=1 on the 2nd clk.
- R-type opcode 000000, mem_ready=1 -> 4 cycles; alu_op=10 in cycle 3; reg_write=1 with reg_dst=1 in cycle 4.
- lw opcode 100011, mem_ready low for 2 cycles in S_FETCH and 3 in S_MEMRD -> 10 cycles total; ir_write exactly one cycle; reg_write with mem_to_reg=1 in the last cycle.
- beq opcode 000100: zero=1 -> pc_en=1, pc_source=01, alu_op=01; zero=0 -> pc_en=0; both cases 3 cycles.
- Opcode 111111 -> illegal_op pulses exactly one cycle in S_DECODE; next cycle S_FETCH; no reg_write or mem_write.
- Opcode 001000, with macro -> reg_write=1, reg_dst=0 in cycle 4; without macro -> illegal_op pulse.
